// File: rtl/multi_key_beep_if.sv
// Key/buzzer signal bundle for multi_key_beep.
// The controller takes the slave view; the board top or a bench takes the master view.
interface multi_key_beep_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key;
    logic [KEY_NUM-1:0] key_value;
    logic [KEY_NUM-1:0] key_flag;
    logic               busy;
    logic               beep;

    modport master (output key, input key_value, key_flag, busy, beep);
    modport slave  (input key, output key_value, key_flag, busy, beep);
endinterface

// File: rtl/multi_key_beep.sv
// Per-key debounce with press strobes, driving one buzzer with an (i+1)-beep chirp for key i.
// state | meaning: IDLE | waiting for a press strobe; ON | beep interval; OFF | silence between beeps
module multi_key_beep #(
    parameter int KEY_NUM       = 4,
    parameter int DEBOUNCE_CNT  = 1_000_000,
    parameter int BEEP_ON_CNT   = 5_000_000,
    parameter int BEEP_OFF_CNT  = 5_000_000,
    parameter int TONE_HALF_CNT = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    multi_key_beep_if.slave   kb
);
    localparam int DB_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int PH_MAX = (BEEP_ON_CNT > BEEP_OFF_CNT) ? BEEP_ON_CNT : BEEP_OFF_CNT;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int REM_W  = $clog2(KEY_NUM + 1);
    localparam int TN_W   = (TONE_HALF_CNT > 1) ? $clog2(TONE_HALF_CNT) : 1;

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(BEEP_ON_CNT - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(BEEP_OFF_CNT - 1);
    localparam logic [TN_W-1:0] TN_LAST  = TN_W'((TONE_HALF_CNT > 0) ? TONE_HALF_CNT - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [KEY_NUM-1:0] sync1_q, sync_q;
    logic [KEY_NUM-1:0] val_q, val_d;
    logic [KEY_NUM-1:0] flag_q, flag_d;
    logic [DB_W-1:0]    db_cnt_q [KEY_NUM];
    logic [DB_W-1:0]    db_cnt_d [KEY_NUM];

    logic [1:0]       state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d, win_rem;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [TN_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic             tone_lvl_q, tone_lvl_d;
    logic             beep_q, beep_d;
    logic             busy_q, busy_d;

    always_comb begin
        val_d  = val_q;
        flag_d = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != val_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    val_d[i]  = sync_q[i];
                    flag_d[i] = ~sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Descending scan so the lowest set strobe is the one that sticks.
    always_comb begin
        win_rem = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (flag_q[i]) win_rem = REM_W'(i + 1);
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        ph_d       = ph_q + PH_W'(1);
        tone_cnt_d = (TONE_HALF_CNT > 0) ? tone_cnt_q + TN_W'(1) : '0;
        tone_lvl_d = tone_lvl_q;
        case (state_q)
            S_IDLE: begin
                ph_d = '0;
                if (|flag_q) begin
                    state_d = S_ON;
                    rem_d   = win_rem;
                end
            end
            S_ON: begin
                if (ph_q == ON_LAST) begin
                    ph_d = '0;
                    if (rem_q == REM_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = rem_q - REM_W'(1);
                        state_d = S_OFF;
                    end
                end
            end
            S_OFF: begin
                if (ph_q == OFF_LAST) begin
                    ph_d    = '0;
                    state_d = S_ON;
                end
            end
            default: begin
                state_d = S_IDLE;
                ph_d    = '0;
            end
        endcase

        // Tone phase restarts high on every ON entry so each beep sounds identical.
        if (state_d != S_ON) begin
            tone_cnt_d = '0;
            tone_lvl_d = 1'b0;
        end else if (state_q != S_ON) begin
            tone_cnt_d = '0;
            tone_lvl_d = 1'b1;
        end else if (TONE_HALF_CNT > 0 && tone_cnt_q == TN_LAST) begin
            tone_cnt_d = '0;
            tone_lvl_d = ~tone_lvl_q;
        end

        beep_d = (state_d == S_ON) && tone_lvl_d;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q    <= '1;
            sync_q     <= '1;
            val_q      <= '1;
            flag_q     <= '0;
            for (int i = 0; i < KEY_NUM; i++) db_cnt_q[i] <= '0;
            state_q    <= S_IDLE;
            rem_q      <= '0;
            ph_q       <= '0;
            tone_cnt_q <= '0;
            tone_lvl_q <= 1'b0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= kb.key;
            sync_q     <= sync1_q;
            val_q      <= val_d;
            flag_q     <= flag_d;
            for (int i = 0; i < KEY_NUM; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q    <= state_d;
            rem_q      <= rem_d;
            ph_q       <= ph_d;
            tone_cnt_q <= tone_cnt_d;
            tone_lvl_q <= tone_lvl_d;
            beep_q     <= beep_d;
            busy_q     <= busy_d;
        end
    end

    assign kb.key_value = val_q;
    assign kb.key_flag  = flag_q;
    assign kb.busy      = busy_q;
    assign kb.beep      = beep_q;
endmodule
